// File: rtl/mem_access_arbiter_m.sv
// Shares one memory-controller port between instruction fetch and data access.
// Latency: 2 cycles request-to-done when mem_done is returned with mem_en; 1 cycle for misaligned.
// Backpressure: requests are level-held until done; one access in flight, the other waits in IDLE.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-low reset
//   fetch_*              fetch unit: word-read request, done/data/err pulse back
//   data_*               data unit: byte/word read/write request, done/data/err pulse back
//   mem_*                memory controller access strobe, attributes, completion
//   grant_fetch/data     which requester currently owns the in-flight access
module mem_access_arbiter_m #(
  parameter int TIMEOUT = 16,
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_done,
  output logic [DATA_W-1:0] fetch_data,
  output logic              fetch_err,
  input  logic              data_req,
  input  logic              data_wr,
  input  logic              data_size,
  input  logic [ADDR_W-1:0] data_addr,
  input  logic [DATA_W-1:0] data_wr_data,
  output logic              data_done,
  output logic [DATA_W-1:0] data_rd_data,
  output logic              data_err,
  output logic              mem_en,
  output logic              mem_wr,
  output logic              mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wr_data,
  input  logic              mem_done,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              mem_err,
  output logic              grant_fetch,
  output logic              grant_data
);

  localparam logic [0:0] S_IDLE   = 1'b0;
  localparam logic [0:0] S_ACCESS = 1'b1;

  localparam int              CNT_W   = $clog2(TIMEOUT + 2);
  localparam bit              TO_EN   = (TIMEOUT != 0);
  // Counter value at which the final waiting cycle is sampled.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  logic [0:0]       state;
  logic             last_grant;   // 0 = fetch, 1 = data
  logic [CNT_W-1:0] cnt;

  logic sel_fetch;
  logic sel_data;
  logic misalign;
  logic timeout_hit;
  logic [DATA_W-1:0] rsp_data;
  logic              rsp_err;

  // Round-robin: on a tie the requester that was not granted last wins.
  assign sel_fetch = fetch_req && (!data_req || last_grant);
  assign sel_data  = data_req  && (!fetch_req || !last_grant);

  // Fetch is always a word access; data only checks alignment for words.
  assign misalign = sel_fetch ? fetch_addr[0] : (data_size && data_addr[0]);

  assign timeout_hit = TO_EN && !mem_done && (cnt == TO_LAST);

  // Completion payload: writes and timeouts return zero data.
  assign rsp_data = (mem_done && !mem_wr) ? mem_data : '0;
  assign rsp_err  = mem_done ? mem_err : 1'b1;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= S_IDLE;
      last_grant   <= 1'b1;
      cnt          <= '0;
      fetch_done   <= 1'b0;
      fetch_data   <= '0;
      fetch_err    <= 1'b0;
      data_done    <= 1'b0;
      data_rd_data <= '0;
      data_err     <= 1'b0;
      mem_en       <= 1'b0;
      mem_wr       <= 1'b0;
      mem_size     <= 1'b0;
      mem_addr     <= '0;
      mem_wr_data  <= '0;
      grant_fetch  <= 1'b0;
      grant_data   <= 1'b0;
    end else begin
      fetch_done <= 1'b0;
      fetch_err  <= 1'b0;
      data_done  <= 1'b0;
      data_err   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (sel_fetch || sel_data) begin
            last_grant <= sel_data;
            if (misalign) begin
              // Rejected without touching memory; answer next cycle.
              if (sel_fetch) begin
                fetch_done <= 1'b1;
                fetch_err  <= 1'b1;
                fetch_data <= '0;
              end else begin
                data_done    <= 1'b1;
                data_err     <= 1'b1;
                data_rd_data <= '0;
              end
            end else begin
              mem_en      <= 1'b1;
              grant_fetch <= sel_fetch;
              grant_data  <= sel_data;
              mem_addr    <= sel_fetch ? fetch_addr : data_addr;
              mem_wr      <= sel_data && data_wr;
              mem_size    <= sel_fetch || data_size;
              mem_wr_data <= sel_fetch ? '0 : data_wr_data;
              cnt         <= '0;
              state       <= S_ACCESS;
            end
          end
        end
        S_ACCESS: begin
          if (mem_done || timeout_hit) begin
            mem_en      <= 1'b0;
            mem_wr      <= 1'b0;
            mem_size    <= 1'b0;
            grant_fetch <= 1'b0;
            grant_data  <= 1'b0;
            state       <= S_IDLE;
            if (grant_fetch) begin
              fetch_done <= 1'b1;
              fetch_err  <= rsp_err;
              fetch_data <= rsp_data;
            end else begin
              data_done    <= 1'b1;
              data_err     <= rsp_err;
              data_rd_data <= rsp_data;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_arbiter_m.sv
// Directed bench for mem_access_arbiter_m with TIMEOUT = 4.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// The memory controller is played by hand in each stimulus step.
module tb_mem_access_arbiter_m;

  localparam int AW = 16;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          fetch_req;
  logic [AW-1:0] fetch_addr;
  logic          fetch_done;
  logic [DW-1:0] fetch_data;
  logic          fetch_err;
  logic          data_req;
  logic          data_wr;
  logic          data_size;
  logic [AW-1:0] data_addr;
  logic [DW-1:0] data_wr_data;
  logic          data_done;
  logic [DW-1:0] data_rd_data;
  logic          data_err;
  logic          mem_en;
  logic          mem_wr;
  logic          mem_size;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wr_data;
  logic          mem_done;
  logic [DW-1:0] mem_data;
  logic          mem_err;
  logic          grant_fetch;
  logic          grant_data;

  int n_chk  = 0;
  int n_fail = 0;

  mem_access_arbiter_m #(.TIMEOUT(4), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk          (clk),
    .reset        (reset),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_done   (fetch_done),
    .fetch_data   (fetch_data),
    .fetch_err    (fetch_err),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_size    (data_size),
    .data_addr    (data_addr),
    .data_wr_data (data_wr_data),
    .data_done    (data_done),
    .data_rd_data (data_rd_data),
    .data_err     (data_err),
    .mem_en       (mem_en),
    .mem_wr       (mem_wr),
    .mem_size     (mem_size),
    .mem_addr     (mem_addr),
    .mem_wr_data  (mem_wr_data),
    .mem_done     (mem_done),
    .mem_data     (mem_data),
    .mem_err      (mem_err),
    .grant_fetch  (grant_fetch),
    .grant_data   (grant_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    fetch_req = 1'b0; fetch_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 1'b0; data_addr = '0; data_wr_data = '0;
    mem_done = 1'b0; mem_data = '0; mem_err = 1'b0;

    // Reset state
    do_reset();
    chk("rst_mem_en", 32'(mem_en), 0);
    chk("rst_grants", 32'({grant_fetch, grant_data}), 0);
    chk("rst_dones", 32'({fetch_done, data_done, fetch_err, data_err}), 0);
    chk("rst_buses", 32'({mem_addr, fetch_data}), 0);

    // Stray mem_done in IDLE is ignored
    mem_done = 1'b1; mem_data = 16'h7777;
    step();
    mem_done = 1'b0;
    chk("idle_memdone_ignored", 32'({fetch_done, data_done, mem_en}), 0);

    // Single fetch, controller answers in the mem_en cycle
    fetch_req = 1'b1; fetch_addr = 16'h0010;
    step();
    chk("f1_mem_en", 32'(mem_en), 1);
    chk("f1_mem_addr", 32'(mem_addr), 32'h0010);
    chk("f1_size_wr", 32'({mem_size, mem_wr}), 32'b10);
    chk("f1_grant", 32'({grant_fetch, grant_data}), 32'b10);
    mem_done = 1'b1; mem_data = 16'hABCD;
    step();
    chk("f1_done", 32'({fetch_done, fetch_err, mem_en}), 32'b100);
    chk("f1_data", 32'(fetch_data), 32'hABCD);
    fetch_req = 1'b0; mem_done = 1'b0;
    step();
    chk("f1_done_pulse", 32'(fetch_done), 0);
    chk("f1_data_hold", 32'(fetch_data), 32'hABCD);

    // Tie after reset: fetch first, then data byte write
    do_reset();
    fetch_req = 1'b1; fetch_addr = 16'h0040;
    data_req = 1'b1; data_wr = 1'b1; data_size = 1'b0; data_addr = 16'h0021; data_wr_data = 16'h0055;
    step();
    chk("tie_grant_fetch", 32'({grant_fetch, grant_data}), 32'b10);
    chk("tie_f_addr", 32'(mem_addr), 32'h0040);
    mem_done = 1'b1; mem_data = 16'h1111;
    step();
    chk("tie_f_done", 32'({fetch_done, data_done}), 32'b10);
    chk("tie_f_data", 32'(fetch_data), 32'h1111);
    mem_done = 1'b0;  // fetch keeps requesting: tie again, data must win
    step();
    chk("tie_grant_data", 32'({grant_fetch, grant_data, mem_en}), 32'b011);
    chk("wr_attr", 32'({mem_wr, mem_size}), 32'b10);
    chk("wr_addr", 32'(mem_addr), 32'h0021);
    chk("wr_data", 32'(mem_wr_data), 32'h0055);
    mem_done = 1'b1; mem_data = 16'h9999;
    step();
    chk("wr_done", 32'({data_done, fetch_done, data_err}), 32'b100);
    chk("wr_rd_zero", 32'(data_rd_data), 0);
    mem_done = 1'b0;  // data keeps requesting: tie, fetch now wins
    step();
    chk("tie2_grant_fetch", 32'({grant_fetch, grant_data}), 32'b10);
    mem_done = 1'b1; mem_data = 16'h2345;
    step();
    chk("tie2_f_done", 32'({fetch_done, data_done}), 32'b10);
    fetch_req = 1'b0; mem_done = 1'b0;
    step();
    chk("tie2_grant_data", 32'({grant_fetch, grant_data}), 32'b01);
    mem_done = 1'b1;
    step();
    chk("tie2_d_done", 32'({fetch_done, data_done}), 32'b01);
    data_req = 1'b0; mem_done = 1'b0;
    step();
    chk("tie2_idle", 32'({grant_fetch, grant_data, mem_en}), 0);

    // Misaligned data word read: no memory access, error next cycle
    data_req = 1'b1; data_wr = 1'b0; data_size = 1'b1; data_addr = 16'h0033;
    step();
    chk("mis_no_mem_en", 32'(mem_en), 0);
    chk("mis_done_err", 32'({data_done, data_err}), 32'b11);
    chk("mis_data_zero", 32'(data_rd_data), 0);
    data_req = 1'b0;
    step();
    chk("mis_pulse", 32'({data_done, data_err, mem_en}), 0);

    // Timeout on data word read with fetch pending
    data_req = 1'b1; data_wr = 1'b0; data_size = 1'b1; data_addr = 16'h0034;
    step();
    chk("to_grant_data", 32'({grant_data, mem_en}), 32'b11);
    fetch_req = 1'b1; fetch_addr = 16'h0050;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk($sformatf("to_mem_en_c%0d", i), 32'({mem_en, data_done}), 32'b10);
    end
    step();
    chk("to_exit", 32'({mem_en, data_done, data_err}), 32'b011);
    chk("to_data_zero", 32'(data_rd_data), 0);
    data_req = 1'b0;
    step();
    chk("to_fetch_next", 32'({grant_fetch, mem_en}), 32'b11);
    chk("to_fetch_addr", 32'(mem_addr), 32'h0050);
    mem_done = 1'b1; mem_data = 16'h2222;
    step();
    chk("to_fetch_done", 32'(fetch_done), 1);
    fetch_req = 1'b0; mem_done = 1'b0;
    step();

    // Controller error on fetch at top of memory
    fetch_req = 1'b1; fetch_addr = 16'hFFFE;
    step();
    chk("err_grant", 32'({grant_fetch, mem_en}), 32'b11);
    mem_done = 1'b1; mem_err = 1'b1; mem_data = 16'h0BAD;
    step();
    chk("err_done", 32'({fetch_done, fetch_err}), 32'b11);
    chk("err_data", 32'(fetch_data), 32'h0BAD);
    fetch_req = 1'b0; mem_done = 1'b0; mem_err = 1'b0;
    step();

    // Reset during ACCESS: abandoned, no done, fetch wins next tie
    fetch_req = 1'b1; fetch_addr = 16'h0060;
    step();
    chk("rma_grant", 32'(grant_fetch), 1);
    reset = 1'b0;
    step();
    chk("rma_cleared", 32'({mem_en, grant_fetch, grant_data, fetch_done}), 0);
    reset = 1'b1;
    fetch_addr = 16'h0070;
    data_req = 1'b1; data_wr = 1'b0; data_size = 1'b1; data_addr = 16'h0080;
    step();
    chk("rma_tie_fetch", 32'({grant_fetch, grant_data}), 32'b10);
    chk("rma_addr", 32'(mem_addr), 32'h0070);
    fetch_req = 1'b0; data_req = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
